// File: rtl/i2s_dac_tx_if.sv
// Sample-pair stream into the I2S transmitter: valid/ready handshake carrying
// one stereo PCM pair per transfer.
interface i2s_dac_tx_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input  s_ready);
  modport slave  (input  s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC transmitter: one-entry sample buffer, BCLK/LRCK
// generation from sys_clk, per-frame attenuation and underrun flagging.
module i2s_dac_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  i2s_dac_tx_if.slave  s,
  input  logic         vol_up,
  input  logic         vol_dn,
  output logic [2:0]   atten,
  output logic         aud_bclk,
  output logic         aud_lrck,
  output logic         aud_dacdat,
  output logic         underrun
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] SLOT_BITS = CNT_W'(SLOT_W);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pcm_pair_t;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               bclk_q, bclk_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               lrck_q, lrck_d;
  logic               dacdat_q, dacdat_d;
  logic               underrun_q, underrun_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  pcm_pair_t          buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic [2:0]         atten_q, atten_d;
  logic [2:0]         up_sync_q, up_sync_d;
  logic [2:0]         dn_sync_q, dn_sync_d;

  logic               div_wrap, bclk_fall, frame_start, up_rise, dn_rise;
  logic signed [DATA_W-1:0] left_att, right_att;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    dacdat_d   = dacdat_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    atten_d    = atten_q;

    left_att  = $signed(buf_q.left)  >>> atten_q;
    right_att = $signed(buf_q.right) >>> atten_q;

    div_wrap    = (div_cnt_q == DIV_LAST);
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d      = bclk_q ^ div_wrap;
    bclk_fall   = div_wrap & bclk_q;
    frame_start = bclk_fall & (bit_cnt_q == CNT_LAST);
    underrun_d  = frame_start & ~buf_full_q;

    if (bclk_fall) begin
      bit_cnt_d = frame_start ? '0 : bit_cnt_q + CNT_W'(1);
      lrck_d    = (bit_cnt_d >= SLOT_BITS);
      if (frame_start) begin
        shreg_d = '0;
        if (buf_full_q) begin
          shreg_d[FRAME_W-1 -: DATA_W] = left_att;
          shreg_d[SLOT_W-1  -: DATA_W] = right_att;
        end
      end else begin
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      end
      // I2S mode emits the bit that was raw before this edge, giving the one-BCLK lag.
      dacdat_d = (MODE == 1) ? shreg_d[FRAME_W-1] : shreg_q[FRAME_W-1];
    end

    if (frame_start && buf_full_q) buf_full_d = 1'b0;
    if (s.s_valid && !buf_full_q) begin
      buf_d      = '{left: s.s_left, right: s.s_right};
      buf_full_d = 1'b1;
    end

    up_sync_d = {up_sync_q[1:0], vol_up};
    dn_sync_d = {dn_sync_q[1:0], vol_dn};
    up_rise   = up_sync_q[1] & ~up_sync_q[2];
    dn_rise   = dn_sync_q[1] & ~dn_sync_q[2];
    case ({up_rise, dn_rise})
      2'b10:   if (atten_q != 3'd0) atten_d = atten_q - 3'd1;
      2'b01:   if (atten_q != 3'd7) atten_d = atten_q + 3'd1;
      default: atten_d = atten_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      lrck_q     <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      atten_q    <= 3'd0;
      up_sync_q  <= 3'd0;
      dn_sync_q  <= 3'd0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      atten_q    <= atten_d;
      up_sync_q  <= up_sync_d;
      dn_sync_q  <= dn_sync_d;
    end
  end

  assign s.s_ready  = ~buf_full_q;
  assign atten      = atten_q;
  assign aud_bclk   = bclk_q;
  assign aud_lrck   = lrck_q;
  assign aud_dacdat = dacdat_q;
  assign underrun   = underrun_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: I2S and left-justified instances share stimulus and are
// checked every cycle against a frame-level model, plus hand-derived bit streams.
module tb_i2s_dac_tx;
  localparam int DW = 16, SW = 16, BD = 2, FW = 2 * SW;

  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, vol_up = 1'b0, vol_dn = 1'b0;
  logic [DW-1:0] s_left = '0, s_right = '0;
  logic [2:0] atten0, atten1;
  logic bclk0, lrck0, dat0, und0, bclk1, lrck1, dat1, und1;
  int checks = 0, fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  i2s_dac_tx_if #(.DATA_W(DW)) if0 ();
  i2s_dac_tx_if #(.DATA_W(DW)) if1 ();
  assign if0.s_valid = s_valid;
  assign if0.s_left  = s_left;
  assign if0.s_right = s_right;
  assign if1.s_valid = s_valid;
  assign if1.s_left  = s_left;
  assign if1.s_right = s_right;

  i2s_dac_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD), .MODE(0)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .s(if0), .vol_up(vol_up), .vol_dn(vol_dn),
    .atten(atten0), .aud_bclk(bclk0), .aud_lrck(lrck0), .aud_dacdat(dat0), .underrun(und0));
  i2s_dac_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD), .MODE(1)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .s(if1), .vol_up(vol_up), .vol_dn(vol_dn),
    .atten(atten1), .aud_bclk(bclk1), .aud_lrck(lrck1), .aud_dacdat(dat1), .underrun(und1));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: cycle count since reset plus the list of frames loaded so far.
  int m_n = 0, m_atten = 0;
  bit m_full = 1'b0, m_und = 1'b0, full_old;
  bit up_r, dn_r;
  logic [DW-1:0] m_l = '0, m_r = '0;
  logic [2:0] m_uph = '0, m_dnh = '0;
  logic [FW-1:0] frames[$];

  function automatic logic [FW-1:0] build(logic [DW-1:0] l, logic [DW-1:0] r, int a);
    logic signed [DW-1:0] sl, sr;
    logic [FW-1:0] w;
    sl = l; sr = r; w = '0;
    w[FW-1 -: DW] = sl >>> a;
    w[SW-1 -: DW] = sr >>> a;
    return w;
  endfunction

  function automatic logic raw(int ff);
    return frames[ff / FW][FW - 1 - (ff % FW)];
  endfunction

  initial begin
    frames.push_back('0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0; m_full = 0; m_und = 0; m_atten = 0; m_uph = '0; m_dnh = '0;
        frames.delete();
        frames.push_back('0);
      end else begin
        full_old = m_full;
        m_n++;
        m_und = 0;
        if (m_n % (2 * BD) == 0 && (m_n / (2 * BD)) % FW == 0) begin
          if (m_full) begin
            frames.push_back(build(m_l, m_r, m_atten));
            m_full = 0;
          end else begin
            frames.push_back('0);
            m_und = 1;
          end
        end
        if (s_valid && !full_old) begin
          m_l = s_left; m_r = s_right; m_full = 1;
        end
        up_r = m_uph[1] && !m_uph[2];
        dn_r = m_dnh[1] && !m_dnh[2];
        if (up_r && !dn_r && m_atten > 0) m_atten--;
        else if (dn_r && !up_r && m_atten < 7) m_atten++;
        m_uph = {m_uph[1:0], vol_up};
        m_dnh = {m_dnh[1:0], vol_dn};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      int f, bc;
      logic [7:0] e0, e1;
      f  = m_n / (2 * BD);
      bc = f % FW;
      e1 = {1'((m_n / BD) % 2), bc >= SW, raw(f), m_und, !m_full, 3'(m_atten)};
      e0 = e1;
      e0[5] = (f == 0) ? 1'b0 : raw(f - 1);
      chk("stream_mode1", {bclk1, lrck1, dat1, und1, if1.s_ready, atten1}, e1);
      chk("stream_mode0", {bclk0, lrck0, dat0, und0, if0.s_ready, atten0}, e0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_frame();
    logic prev;
    bit ok;
    prev = lrck1; ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (prev && !lrck1) begin ok = 1; break; end
      prev = lrck1;
    end
    chk("frame_start_seen", ok, 1);
  endtask

  task automatic capture(output logic [31:0] w0, output logic [31:0] w1);
    w0 = '0; w1 = '0;
    for (int i = 0; i < FW; i++) begin
      w0 = {w0[30:0], dat0};
      w1 = {w1[30:0], dat1};
      if (i < FW - 1) repeat (2 * BD) @(negedge clk);
    end
  endtask

  task automatic push(logic [DW-1:0] l, logic [DW-1:0] r);
    s_valid = 1; s_left = l; s_right = r;
    @(negedge clk);
    s_valid = 0;
    chk("push_ready_low", if1.s_ready, 0);
  endtask

  task automatic vol_pulses(int up_n, int dn_n, int hold);
    int m;
    m = (up_n > dn_n) ? up_n : dn_n;
    for (int i = 0; i < m; i++) begin
      vol_up = (i < up_n); vol_dn = (i < dn_n);
      repeat (hold) @(negedge clk);
      vol_up = 0; vol_dn = 0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct { int up_n; int dn_n; int hold; logic [2:0] exp_atten; } vol_vec_t;
  vol_vec_t vt[7];

  initial begin
    logic [31:0] w0, w1, a0, a1, b0, b1;
    int und_cnt, ones, stalls;
    vt[0] = '{0, 1, 100, 3'd1};
    vt[1] = '{0, 9, 4, 3'd7};
    vt[2] = '{2, 0, 4, 3'd5};
    vt[3] = '{9, 0, 4, 3'd0};
    vt[4] = '{1, 0, 4, 3'd0};
    vt[5] = '{0, 3, 4, 3'd3};
    vt[6] = '{1, 1, 4, 3'd3};

    repeat (3) @(negedge clk);
    chk("reset_state", {bclk0, lrck0, dat0, und0, if0.s_ready, atten0,
                        bclk1, lrck1, dat1, und1, if1.s_ready, atten1}, 16'h0808);
    rst_n = 1; chk_en = 1;

    // Pair pushed right after reset goes out in the frame after the first boundary.
    push(16'hA5F0, 16'h0F0F);
    wait_frame();
    capture(w0, w1);
    chk("t1_lj_frame", w1, 32'hA5F00F0F);
    chk("t2_i2s_frame", w0, 32'h52F80787);

    // Three idle frames: zero data, one underrun per frame.
    repeat (2 * BD) @(negedge clk);
    und_cnt = 0; ones = 0;
    for (int i = 0; i < 3 * FW * 2 * BD; i++) begin
      und_cnt += int'(und1);
      ones += int'(dat1);
      @(negedge clk);
    end
    chk("t3_underruns", und_cnt, 3);
    chk("t3_zero_data", ones, 0);

    // Back-to-back pairs with valid held: second stalls until the first loads.
    wait_frame();
    stalls = 0;
    fork
      begin
        s_valid = 1; s_left = 16'h1234; s_right = 16'h5678;
        @(negedge clk);
        chk("t4_first_taken", if1.s_ready, 0);
        s_left = 16'h9ABC; s_right = 16'hDEF0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (if1.s_ready) break;
          stalls++;
        end
        @(negedge clk);
        s_valid = 0;
      end
      begin
        wait_frame();
        capture(a0, a1);
        wait_frame();
        capture(b0, b1);
      end
    join
    chk("t4_stall_len", stalls, 126);
    chk("t4_frame1", a1, 32'h12345678);
    chk("t4_frame2", b1, 32'h9ABCDEF0);
    chk("t4_frame2_i2s", b0, 32'h4D5E6F78);

    for (int i = 0; i < 7; i++) begin
      vol_pulses(vt[i].up_n, vt[i].dn_n, vt[i].hold);
      chk($sformatf("t5_atten_vec%0d", i), {atten0, atten1}, {vt[i].exp_atten, vt[i].exp_atten});
    end
    wait_frame();
    push(16'h8000, 16'h7FFF);
    wait_frame();
    capture(w0, w1);
    chk("t5_atten3_frame", w1, 32'hF0000FFF);

    // Reset in the right slot with a buffered pair: everything clears at once.
    wait_frame();
    push(16'h1111, 16'h2222);
    repeat (80) @(negedge clk);
    chk("t6_full_before_rst", if1.s_ready, 0);
    #2 rst_n = 0;
    #1 chk("t6_async_reset", {bclk0, lrck0, dat0, und0, if0.s_ready, atten0,
                              bclk1, lrck1, dat1, und1, if1.s_ready, atten1}, 16'h0808);
    repeat (3) @(negedge clk);
    rst_n = 1;
    und_cnt = 0; ones = 0;
    for (int i = 0; i < FW * 2 * BD; i++) begin
      @(negedge clk);
      und_cnt += int'(und1);
      ones += int'(dat1) + int'(dat0);
    end
    chk("t6_first_underrun", und_cnt, 1);
    chk("t6_zero_data", ones, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
